// File: rtl/sys_bridge_tc_if.sv
// CPU data-port bundle between the pipeline M stage and sys_bridge_tc.
//   m_data_addr    CPU byte address
//   m_data_wdata   CPU write data, already lane-shifted
//   m_data_byteen  CPU byte enables (4'h0 = read / no write)
//   m_data_rdata   combinational read data back to the CPU
// Modports: master = CPU side, slave = bridge side.
interface sys_bridge_tc_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;

  modport master (output m_data_addr, output m_data_wdata, output m_data_byteen,
                  input  m_data_rdata);
  modport slave  (input  m_data_addr, input  m_data_wdata, input  m_data_byteen,
                  output m_data_rdata);
endinterface

// File: rtl/sys_bridge_tc.sv
// sys_bridge_tc: responder for the CPU data port. Decodes each access to data
// memory, timer 0 or timer 1, and owns two down-counting timers with IRQs.
// Reads are same-cycle (combinational); writes commit on the rising clk edge.
//
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   cpu          sys_bridge_tc_if.slave (m_data_addr/wdata/byteen/rdata)
//   dm_addr      = m_data_addr
//   dm_wdata     = m_data_wdata
//   dm_byteen    = m_data_byteen when address is in DM range, else 4'h0
//   dm_rdata     combinational DM read data
//   irq[i]       CTRL_i.IM & flag_i
//
// Timer register map (word offsets from TCi_BASE): CTRL +0, PRESET +4, COUNT +8.
// CTRL[3]=IM, CTRL[2:1]=MODE (01 auto-reload, else one-shot), CTRL[0]=EN.
//
// Build option: define SYS_BRIDGE_TC1_EN to instantiate timer 1. Without it the
// TC1 window still decodes to the bridge but reads 0, drops writes, irq[1]=0.
module sys_bridge_tc #(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter logic [31:0] DM_END   = 32'h0000_2FFF,
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
  input  logic                  clk,
  input  logic                  reset,
  sys_bridge_tc_if.slave        cpu,
  output logic [31:0]           dm_addr,
  output logic [31:0]           dm_wdata,
  output logic [3:0]            dm_byteen,
  input  logic [31:0]           dm_rdata,
  output logic [1:0]            irq
);

`ifdef SYS_BRIDGE_TC1_EN
  localparam int unsigned NUM_TC = 2;
`else
  localparam int unsigned NUM_TC = 1;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_CNT, ST_INT} tc_state_t;

  // 33-bit differences give range checks that stay well-formed when DM_BASE is 0.
  logic [32:0] dm_lo_diff;
  logic [32:0] dm_hi_diff;
  logic        dm_hit;
  logic [1:0]  reg_sel;
  logic        full_wr;

  assign dm_lo_diff = {1'b0, cpu.m_data_addr} - {1'b0, DM_BASE};
  assign dm_hi_diff = {1'b0, DM_END} - {1'b0, cpu.m_data_addr};
  assign dm_hit     = ~dm_lo_diff[32] & ~dm_hi_diff[32];

  assign dm_addr   = cpu.m_data_addr;
  assign dm_wdata  = cpu.m_data_wdata;
  assign dm_byteen = dm_hit ? cpu.m_data_byteen : 4'h0;

  assign reg_sel = cpu.m_data_addr[3:2];
  assign full_wr = (cpu.m_data_byteen == 4'hF);

  logic [NUM_TC-1:0]       tc_hit;
  logic [NUM_TC-1:0]       tc_irq;
  logic [NUM_TC-1:0][31:0] tc_rdata;

  for (genvar g = 0; g < NUM_TC; g++) begin : g_tc
    localparam logic [31:0] BASE = (g == 0) ? TC0_BASE : TC1_BASE;

    tc_state_t   state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    logic        ctrl_wr;
    logic        preset_wr;
    logic [31:0] rd;

    assign tc_hit[g]  = (cpu.m_data_addr[31:4] == BASE[31:4]) && (reg_sel != 2'b11);
    assign ctrl_wr    = tc_hit[g] & full_wr & (reg_sel == 2'b00);
    assign preset_wr  = tc_hit[g] & full_wr & (reg_sel == 2'b01);
    assign tc_irq[g]  = ctrl[3] & flag;

    // A CTRL write restarts the timer from IDLE and takes priority over the
    // normal state step, including a CNT->INT transition on the same edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= ST_IDLE;
        ctrl   <= '0;
        preset <= '0;
        count  <= '0;
        flag   <= 1'b0;
      end else if (ctrl_wr) begin
        ctrl  <= cpu.m_data_wdata[3:0];
        state <= ST_IDLE;
        flag  <= 1'b0;
      end else begin
        if (preset_wr) preset <= cpu.m_data_wdata;
        case (state)
          ST_IDLE: begin
            if (ctrl[0]) begin
              count <= preset;
              state <= ST_CNT;
            end
          end
          ST_CNT: begin
            if (count != '0) begin
              count <= count - 32'd1;
            end else begin
              state <= ST_INT;
              flag  <= 1'b1;
            end
          end
          ST_INT: begin
            if (ctrl[2:1] == 2'b01) begin
              flag  <= 1'b0;
              count <= preset;
              state <= ST_CNT;
            end else begin
              ctrl[0] <= 1'b0;
              state   <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    always_comb begin
      rd = '0;
      case (reg_sel)
        2'b00:   rd = {28'h0, ctrl};
        2'b01:   rd = preset;
        2'b10:   rd = count;
        default: rd = '0;
      endcase
    end

    assign tc_rdata[g] = rd;
  end

  always_comb begin
    cpu.m_data_rdata = '0;
    if (dm_hit) cpu.m_data_rdata = dm_rdata;
    for (int unsigned i = 0; i < NUM_TC; i++) begin
      if (tc_hit[i]) cpu.m_data_rdata = tc_rdata[i];
    end
  end

`ifdef SYS_BRIDGE_TC1_EN
  assign irq = tc_irq;
`else
  assign irq = {1'b0, tc_irq};
`endif

endmodule

// File: tb/tb_sys_bridge_tc.sv
module tb_sys_bridge_tc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_rdata = 32'hA5A5_0001;
  logic [1:0]  irq;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

`ifdef SYS_BRIDGE_TC1_EN
  localparam bit TC1 = 1'b1;
`else
  localparam bit TC1 = 1'b0;
`endif

  sys_bridge_tc_if bus ();

  sys_bridge_tc dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (bus.slave),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_byteen (dm_byteen),
    .dm_rdata  (dm_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Bus write: drives during the low phase, commits at the next rising edge,
  // returns 1 time unit after that edge with byteen cleared.
  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.m_data_addr   = a;
    bus.m_data_wdata  = d;
    bus.m_data_byteen = be;
    @(posedge clk);
    #1;
    bus.m_data_byteen = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.m_data_byteen = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [4] = '{32'h7F00, 32'h7F04, 32'h7F08, 32'h7F0C};
    do_reset();
    n_cmp++;
    if (irq !== 2'b00) begin
      n_fail++; $display("FAIL reset_irq: got %b expected 00", irq);
    end
    for (int i = 0; i < 4; i++) begin
      bus.m_data_addr = addrs[i];
      #1;
      n_cmp++;
      if (bus.m_data_rdata !== 32'h0) begin
        n_fail++; $display("FAIL reset_read[%h]: got %h expected 0", addrs[i], bus.m_data_rdata);
      end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    cpu_write(32'h7F04, 32'd3, 4'hF);
    cpu_write(32'h7F00, 32'h9, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (irq[0] !== (k >= 5)) begin
        n_fail++; $display("FAIL oneshot_irq k=%0d: got %b expected %b", k, irq[0], (k >= 5));
      end
    end
    bus.m_data_addr = 32'h7F00;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'h8) begin
      n_fail++; $display("FAIL oneshot_ctrl: got %h expected 8", bus.m_data_rdata);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] exp_cnt;
    do_reset();
    cpu_write(32'h7F04, 32'd2, 4'hF);
    cpu_write(32'h7F00, 32'hB, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      bus.m_data_addr = 32'h7F08;
      #1;
      case ((k - 1) % 4)
        0:       exp_cnt = 32'd2;
        1:       exp_cnt = 32'd1;
        default: exp_cnt = 32'd0;
      endcase
      n_cmp++;
      if (bus.m_data_rdata !== exp_cnt) begin
        n_fail++; $display("FAIL reload_count k=%0d: got %0d expected %0d", k, bus.m_data_rdata, exp_cnt);
      end
      n_cmp++;
      if (irq[0] !== (k % 4 == 0)) begin
        n_fail++; $display("FAIL reload_irq k=%0d: got %b expected %b", k, irq[0], (k % 4 == 0));
      end
    end
  endtask

  task automatic test_decode();
    do_reset();
    @(negedge clk);
    bus.m_data_addr = 32'h7F00; bus.m_data_wdata = 32'h0; bus.m_data_byteen = 4'hF;
    #1;
    n_cmp++;
    if (dm_byteen !== 4'h0) begin
      n_fail++; $display("FAIL dec_tc_byteen: got %h expected 0", dm_byteen);
    end
    bus.m_data_addr = 32'h1000; bus.m_data_wdata = 32'h1234_5678; bus.m_data_byteen = 4'h3;
    #1;
    n_cmp++;
    if (dm_byteen !== 4'h3 || dm_addr !== 32'h1000 || dm_wdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL dec_dm_pass: got be=%h a=%h d=%h expected be=3 a=1000 d=12345678",
                         dm_byteen, dm_addr, dm_wdata);
    end
    bus.m_data_addr = 32'h2FFF; bus.m_data_byteen = 4'hF;
    #1;
    n_cmp++;
    if (dm_byteen !== 4'hF) begin
      n_fail++; $display("FAIL dec_dm_end: got %h expected f", dm_byteen);
    end
    bus.m_data_addr = 32'h3000;
    #1;
    bus.m_data_byteen = 4'h0;
    n_cmp++;
    if (dm_byteen !== 4'h0) begin
      n_fail++; $display("FAIL dec_past_end: got %h expected 0", dm_byteen);
    end
    bus.m_data_addr = 32'h2000;
    dm_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL dec_dm_read: got %h expected deadbeef", bus.m_data_rdata);
    end
    bus.m_data_addr = 32'h3000;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'h0) begin
      n_fail++; $display("FAIL dec_unmapped_read: got %h expected 0", bus.m_data_rdata);
    end
  endtask

  task automatic test_ctrl_collision();
    do_reset();
    cpu_write(32'h7F04, 32'd1, 4'hF);
    cpu_write(32'h7F00, 32'h9, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    // COUNT is 0 in CNT here; the next edge would raise the flag.
    cpu_write(32'h7F00, 32'h8, 4'hF);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (irq[0] !== 1'b0) begin
        n_fail++; $display("FAIL coll_noflag k=%0d: got %b expected 0", k, irq[0]);
      end
      @(posedge clk);
      #1;
    end
    bus.m_data_addr = 32'h7F00;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'h8) begin
      n_fail++; $display("FAIL coll_ctrl: got %h expected 8", bus.m_data_rdata);
    end
    // Same collision with EN=1: timer restarts from IDLE instead.
    cpu_write(32'h7F00, 32'h9, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    cpu_write(32'h7F00, 32'h9, 4'hF);
    n_cmp++;
    if (irq[0] !== 1'b0) begin
      n_fail++; $display("FAIL coll_en_noflag: got %b expected 0", irq[0]);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      bus.m_data_addr = 32'h7F08;
      #1;
      n_cmp++;
      if (bus.m_data_rdata !== ((k == 1) ? 32'd1 : 32'd0) || irq[0] !== (k == 3)) begin
        n_fail++; $display("FAIL coll_reload k=%0d: got cnt=%0d irq=%b expected cnt=%0d irq=%b",
                           k, bus.m_data_rdata, irq[0], (k == 1) ? 1 : 0, (k == 3));
      end
    end
    cpu_write(32'h7F04, 32'hFF, 4'h1);
    bus.m_data_addr = 32'h7F04;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'd1) begin
      n_fail++; $display("FAIL partial_preset: got %h expected 1", bus.m_data_rdata);
    end
    cpu_write(32'h7F08, 32'h55, 4'hF);
    bus.m_data_addr = 32'h7F08;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'd0) begin
      n_fail++; $display("FAIL count_readonly: got %h expected 0", bus.m_data_rdata);
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] addrs [5] = '{32'h7F00, 32'h7F04, 32'h7F08, 32'h7F0C, 32'h4000};
    do_reset();
    cpu_write(32'h7F04, 32'd10, 4'hF);
    cpu_write(32'h7F00, 32'h9, 4'hF);
    repeat (4) @(posedge clk);
    #1;
    bus.m_data_addr = 32'h7F08;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'd7) begin
      n_fail++; $display("FAIL mid_count: got %0d expected 7", bus.m_data_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dm_rdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      bus.m_data_addr = addrs[i];
      #1;
      n_cmp++;
      if (bus.m_data_rdata !== 32'h0) begin
        n_fail++; $display("FAIL rst_mid_read[%h]: got %h expected 0", addrs[i], bus.m_data_rdata);
      end
    end
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (irq !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_irq: got %b expected 00", irq);
    end
  endtask

  task automatic test_tc1();
    do_reset();
    cpu_write(32'h7F04, 32'd5, 4'hF);
    cpu_write(32'h7F14, 32'd3, 4'hF);
    cpu_write(32'h7F10, 32'h9, 4'hF);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (irq !== {(TC1 && k >= 5), 1'b0}) begin
        n_fail++; $display("FAIL tc1_irq k=%0d: got %b expected %b%b", k, irq, (TC1 && k >= 5), 1'b0);
      end
    end
    bus.m_data_addr = 32'h7F10;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== (TC1 ? 32'h8 : 32'h0)) begin
      n_fail++; $display("FAIL tc1_ctrl: got %h expected %h", bus.m_data_rdata, TC1 ? 32'h8 : 32'h0);
    end
    bus.m_data_addr = 32'h7F14;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== (TC1 ? 32'd3 : 32'd0)) begin
      n_fail++; $display("FAIL tc1_preset: got %h expected %h", bus.m_data_rdata, TC1 ? 32'd3 : 32'd0);
    end
    bus.m_data_addr = 32'h7F04;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'd5) begin
      n_fail++; $display("FAIL tc0_isolated: got %h expected 5", bus.m_data_rdata);
    end
  endtask

  initial begin
    bus.m_data_addr   = 32'h0;
    bus.m_data_wdata  = 32'h0;
    bus.m_data_byteen = 4'h0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_decode();
    test_ctrl_collision();
    test_reset_midcount();
    test_tc1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
